// File: rtl/br_delay_credit_buffer.sv
// br_delay_credit_buffer: credit-gated receive buffer behind a fixed-latency delay line, presented as ready/valid
module br_delay_credit_buffer #(
  parameter int Width = 1,
  parameter int Depth = 2,
  parameter int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  push_valid,
  input  logic [Width-1:0]      push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [Width-1:0]      pop_data,
  output logic [CountWidth-1:0] credit_count,
  output logic [CountWidth-1:0] items
);
  localparam int PtrWidth = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CountWidth-1:0] Full = CountWidth'(Depth);
  logic [Width-1:0] mem [Depth];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic issue, pop;
  assign issue_ready = credit_count != '0;
  assign pop_valid = items != '0;
  assign pop_data = mem[rd_ptr];
  assign issue = issue_valid && issue_ready;
  assign pop = pop_valid && pop_ready;
  always_ff @(posedge clk)
    if (rst) begin
      credit_count <= Full;
      items <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      credit_count <= credit_count + CountWidth'(pop) - CountWidth'(issue);
      items <= items + CountWidth'(push_valid) - CountWidth'(pop);
      if (push_valid) wr_ptr <= wr_ptr == LastPtr ? '0 : wr_ptr + PtrWidth'(1);
      if (pop) rd_ptr <= rd_ptr == LastPtr ? '0 : rd_ptr + PtrWidth'(1);
    end
  always_ff @(posedge clk)
    if (push_valid) mem[wr_ptr] <= push_data;
  assert property (@(posedge clk) disable iff (rst) issue_valid |-> issue_ready);
  assert property (@(posedge clk) disable iff (rst) push_valid |-> items != Full);
  assert property (@(posedge clk) disable iff (rst) credit_count <= Full);
  assert property (@(posedge clk) disable iff (rst) pop_valid && !pop_ready |=> pop_valid && $stable(pop_data));
endmodule

// File: tb/tb_br_delay_credit_buffer.sv
// tb_br_delay_credit_buffer: scoreboard bench with a 3-stage delay line, Depth 4 (g=0) and Depth 3 (g=1) instances
module tb_br_delay_credit_buffer;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] iv = '0, pr = '0, ir, pv, popv;
  logic [1:0][7:0] id = '0, pd, popd;
  logic [1:0][2:0] cc, it;
  logic [1:0][L-1:0] sv;
  logic [1:0][L-1:0][7:0] sd;
  int checks = 0, errors = 0;
  logic [7:0] q[2][$];
  int outst[2], held[2];
  bit live = 1'b0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = g == 0 ? 4 : 3;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] c, n;
    br_delay_credit_buffer #(.Width(8), .Depth(D)) u_dut (
      .clk(clk), .rst(rst),
      .issue_valid(iv[g]), .issue_ready(ir[g]),
      .push_valid(pv[g]), .push_data(pd[g]),
      .pop_valid(popv[g]), .pop_ready(pr[g]), .pop_data(popd[g]),
      .credit_count(c), .items(n)
    );
    assign cc[g] = 3'(c);
    assign it[g] = 3'(n);
    assign pv[g] = sv[g][L-1];
    assign pd[g] = sd[g][L-1];
  end
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (rst) sv[g] <= '0;
      else begin
        sv[g] <= {sv[g][L-2:0], iv[g] & ir[g]};
        sd[g] <= {sd[g][L-2:0], id[g]};
      end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    int d, fly;
    for (int g = 0; g < 2; g++) begin
      d = g == 0 ? 4 : 3;
      fly = $countones(sv[g]);
      if (live) begin
        check($sformatf("credit_count%0d", g), int'(cc[g]), d - outst[g]);
        check($sformatf("items%0d", g), int'(it[g]), held[g]);
        check($sformatf("issue_ready%0d", g), int'(ir[g]), int'(d - outst[g] != 0));
        check($sformatf("pop_valid%0d", g), int'(popv[g]), int'(held[g] != 0));
        check($sformatf("conservation%0d", g), int'(cc[g]) + fly + int'(it[g]), d);
      end
      if (rst) begin
        q[g].delete();
        outst[g] = 0;
        held[g] = 0;
        live = 1'b1;
      end else if (live) begin
        if (popv[g] && pr[g]) begin
          if (q[g].size() == 0) check($sformatf("pop_unexpected%0d", g), 1, 0);
          else begin
            check($sformatf("pop_data%0d", g), int'(popd[g]), int'(q[g][0]));
            void'(q[g].pop_front());
          end
          outst[g]--;
          held[g]--;
        end
        if (iv[g] && ir[g]) begin
          q[g].push_back(id[g]);
          outst[g]++;
        end
        if (pv[g]) held[g]++;
      end
    end
  end
  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic drain(input int g);
    iv[g] = 1'b0;
    pr[g] = 1'b1;
    for (int i = 0; i < 60 && q[g].size() != 0; i++) step();
    check($sformatf("drain%0d", g), q[g].size(), 0);
    pr[g] = 1'b0;
  endtask
  initial begin
    int n;
    step(2);
    rst = 1'b0;
    check("reset_credit_count", int'(cc[0]), 4);
    check("reset_items", int'(it[0]), 0);
    check("reset_issue_ready", int'(ir[0]), 1);
    check("reset_pop_valid", int'(popv[0]), 0);
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1;
      id[0] = 8'(8'h11 * (i + 1));
      step();
    end
    iv[0] = 1'b0;
    check("fill_issue_ready_c4", int'(ir[0]), 0);
    step(3);
    check("fill_items_c7", int'(it[0]), 4);
    drain(0);
    pr[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      iv[0] = ir[0];
      id[0] = 8'($urandom);
      step();
    end
    drain(0);
    for (int i = 0; i < 200; i++) begin
      iv[0] = ir[0] & 1'($urandom);
      id[0] = 8'($urandom);
      pr[0] = 1'($urandom);
      step();
    end
    drain(0);
    for (int i = 0; i < 5; i++) begin
      iv[0] = i == 0 || i == 1 || i == 3;
      id[0] = 8'(8'hc0 + i);
      step();
    end
    iv[0] = 1'b0;
    check("midrst_items_before", int'(it[0]), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_items", int'(it[0]), 0);
    check("midrst_credit_count", int'(cc[0]), 4);
    step(4);
    check("midrst_no_push", int'(it[0]), 0);
    iv[0] = 1'b1;
    id[0] = 8'ha5;
    step();
    iv[0] = 1'b0;
    for (int i = 0; i < 20 && !popv[0]; i++) step();
    check("midrst_a5_valid", int'(popv[0]), 1);
    check("midrst_a5_data", int'(popd[0]), 8'ha5);
    drain(0);
    for (int i = 0; i < 4; i++) begin
      iv[0] = i != 1;
      id[0] = 8'(8'h50 + i);
      step();
    end
    check("simul_pre_credit", int'(cc[0]), 1);
    check("simul_pre_items", int'(it[0]), 1);
    iv[0] = 1'b1;
    id[0] = 8'h5f;
    pr[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    pr[0] = 1'b0;
    check("simul_credit", int'(cc[0]), 1);
    check("simul_items", int'(it[0]), 0);
    drain(0);
    n = 0;
    for (int i = 0; i < 300 && (n < 12 || q[1].size() != 0); i++) begin
      iv[1] = n < 12 && ir[1] && 1'($urandom);
      id[1] = 8'($urandom);
      if (iv[1]) n++;
      pr[1] = 1'($urandom);
      step();
    end
    check("wrap_issued", n, 12);
    drain(1);
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
